// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter must hold LATENCY-1; keep at least one bit for LATENCY of 1 or 2.
    function automatic int cnt_width(input int latency);
        return (latency <= 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with synchronous write and synchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic                           re_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [WORD_W-1:0]              wdata_i,
    output logic [WORD_W-1:0]              rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Read register returns to zero when not reading, so it only carries data in RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[idx_i];
        end else begin
            rdata_o <= '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request and pulse response.
// Optional DMEM_MISALIGN_CHECK_EN flags and suppresses misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic [WORD_W-1:0] req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              stall_o,
    output logic              err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = cnt_width(LATENCY);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic          mis_q;
    logic [AW-1:0] idx_q;

    logic          req_mis;
    logic          accept;
    logic          go_resp;
    logic          resp_wr;
    logic          resp_mis;
    logic [AW-1:0] arr_idx;
    logic          arr_we;
    logic          arr_re;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic unused_addr;
    assign unused_addr = ^req_addr_i[WORD_W-1:AW+2];
    assign req_mis     = |req_addr_i[1:0];
`else
    logic unused_addr;
    assign unused_addr = ^{req_addr_i[WORD_W-1:AW+2], req_addr_i[1:0]};
    assign req_mis     = 1'b0;
`endif

    assign req_ready_o = (state == IDLE);
    assign stall_o     = ((state == IDLE) && req_valid_i) || (state == WAIT);
    assign accept      = req_ready_o && req_valid_i && !rst_i;

    // With LATENCY of 1 the acceptance edge is also the RESP entry edge.
    assign go_resp = !rst_i &&
                     ((accept && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt == CW'(1))));

    assign resp_wr  = (state == IDLE) ? req_write_i : wr_q;
    assign resp_mis = (state == IDLE) ? req_mis : mis_q;
    assign arr_idx  = (state == IDLE) ? req_addr_i[AW+1:2] : idx_q;
    assign arr_we   = accept && req_write_i && !req_mis;
    assign arr_re   = go_resp && !resp_wr && !resp_mis;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .idx_i  (arr_idx),
        .wdata_i(req_wdata_i),
        .rdata_o(rsp_rdata_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_q        <= 1'b0;
            mis_q       <= 1'b0;
            idx_q       <= '0;
            rsp_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= go_resp;
            err_o       <= go_resp && resp_mis;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q  <= req_write_i;
                        mis_q <= req_mis;
                        idx_q <= req_addr_i[AW+1:2];
                        cnt   <= CW'(LATENCY - 1);
                        state <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY 3, 256 words).
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (3)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_write_i(req_write),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .stall_o    (stall),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request starting at a negedge and observe 12 cycles.
    task automatic run_req(input logic w, input logic [31:0] a,
                           input logic [31:0] d,
                           output int acc_cyc, output int rsp_cyc,
                           output int rsp_w, output int stall_n,
                           output logic [31:0] rd, output logic er);
        acc_cyc = -1;
        rsp_cyc = -1;
        rsp_w   = 0;
        stall_n = 0;
        rd      = 32'hx;
        er      = 1'bx;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (stall) stall_n++;
            if (rsp_valid) begin
                if (rsp_cyc < 0) begin
                    rsp_cyc = k;
                    rd = rsp_rdata;
                    er = err;
                end
                rsp_w++;
            end
            if (req_valid && req_ready && acc_cyc < 0) acc_cyc = k;
            @(posedge clk);
            #1;
            if (acc_cyc >= 0) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        int pulses;
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got %b want 0", stall);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", err);
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", rsp_rdata);
        end
        req_valid = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_follows got %b want 1", stall);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_no_accept pulses got %0d want 0", pulses);
        end
    endtask

    task automatic test_store_load;
        int a, r, w, s;
        logic [31:0] rd;
        logic er;
        run_req(1'b1, 32'h10, 32'hDEADBEEF, a, r, w, s, rd, er);
        checks++;
        if (r - a !== 3) begin
            errors++;
            $display("FAIL store_latency got %0d want 3", r - a);
        end
        checks++;
        if (s !== 3) begin
            errors++;
            $display("FAIL store_stall_cycles got %0d want 3", s);
        end
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL store_pulse_width got %0d want 1", w);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_rsp got %h/%b want 0/0", rd, er);
        end
        run_req(1'b0, 32'h10, 32'h0, a, r, w, s, rd, er);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_data got %h want deadbeef", rd);
        end
        checks++;
        if (r - a !== 3 || w !== 1) begin
            errors++;
            $display("FAIL load_timing got lat %0d width %0d want 3 1", r - a, w);
        end
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL load_err got %b want 0", er);
        end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        int ready_low;
        int pulses;
        int bad;
        ready_low = 0;
        pulses = 0;
        bad = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h10;
        for (int k = 0; k < 14; k++) begin
            #1;
            if (req_ready) acc.push_back(k);
            else ready_low++;
            if (rsp_valid) begin
                pulses++;
                if (rsp_rdata !== 32'hDEADBEEF) bad++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc.size() !== 4) begin
            errors++;
            $display("FAIL b2b_accepts got %0d want 4", acc.size());
        end else begin
            checks++;
            if (acc[1] - acc[0] !== 4 || acc[3] - acc[2] !== 4) begin
                errors++;
                $display("FAIL b2b_spacing got %0d %0d want 4 4",
                         acc[1] - acc[0], acc[3] - acc[2]);
            end
        end
        checks++;
        if (ready_low !== 10) begin
            errors++;
            $display("FAIL b2b_ready_low got %0d want 10", ready_low);
        end
        checks++;
        if (pulses !== 3 || bad !== 0) begin
            errors++;
            $display("FAIL b2b_rsp got pulses %0d bad %0d want 3 0", pulses, bad);
        end
    endtask

    task automatic test_wrap;
        int a, r, w, s;
        logic [31:0] rd;
        logic er;
        run_req(1'b1, 32'h0, 32'h55, a, r, w, s, rd, er);
        run_req(1'b1, 32'h400, 32'h11, a, r, w, s, rd, er);
        run_req(1'b0, 32'h0, 32'h0, a, r, w, s, rd, er);
        checks++;
        if (rd !== 32'h11) begin
            errors++;
            $display("FAIL wrap_data got %h want 00000011", rd);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        int a, r, w, s;
        logic [31:0] rd;
        logic er;
        run_req(1'b1, 32'h20, 32'h0BADF00D, a, r, w, s, rd, er);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle got ready %b stall %b want 1 0", req_ready, stall);
        end
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midrst_dropped pulses got %0d want 0", pulses);
        end
        run_req(1'b0, 32'h20, 32'h0, a, r, w, s, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D || r - a !== 3) begin
            errors++;
            $display("FAIL midrst_store_kept got %h lat %0d want cafef00d 3", rd, r - a);
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midrst_load_dropped pulses got %0d want 0", pulses);
        end
        run_req(1'b0, 32'h10, 32'h0, a, r, w, s, rd, er);
        checks++;
        if (rd !== 32'hDEADBEEF || w !== 1) begin
            errors++;
            $display("FAIL midrst_next_load got %h width %0d want deadbeef 1", rd, w);
        end
    endtask

    task automatic test_misalign;
        int a, r, w, s;
        logic [31:0] rd;
        logic er;
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_err  = 1'b1;
        exp_word = 32'hDEADBEEF;
`else
        exp_err  = 1'b0;
        exp_word = 32'h12345678;
`endif
        run_req(1'b1, 32'h13, 32'h12345678, a, r, w, s, rd, er);
        checks++;
        if (er !== exp_err || r - a !== 3) begin
            errors++;
            $display("FAIL misalign_err got %b lat %0d want %b 3", er, r - a, exp_err);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL misalign_rdata got %h want 0", rd);
        end
        run_req(1'b0, 32'h10, 32'h0, a, r, w, s, rd, er);
        checks++;
        if (rd !== exp_word || er !== 1'b0) begin
            errors++;
            $display("FAIL misalign_word got %h/%b want %h/0", rd, er, exp_word);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
